// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and constants for the CNN front-end blocks.
//   PIX_W          : raw source pixel width (unsigned 8-bit)
//   Q88_W          : normalized pixel width (Q8.8 fixed point)
//   frame_state_e  : frame controller FSM states
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int PIX_W = 8;
    localparam int Q88_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } frame_state_e;

endpackage : cnn_pkg

// File: rtl/norm_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// norm_frame_ctrl_if
// Groups the three data paths of the frame controller:
//   rd_*            : source pixel-buffer read port (rd_data valid 1 cycle after rd_en)
//   norm_*          : PixelNormalizer stream (pixel_in/valid_in out, pixel_out/valid_out back)
//   wr_*            : destination feature-buffer write port (completes on wr_en && wr_ready)
// Modports:
//   master : the controller side
//   slave  : the environment side (buffers + normalizer)
// -----------------------------------------------------------------------------
interface norm_frame_ctrl_if #(
    parameter int ADDR_W = 10
);

    logic                       rd_en;
    logic [ADDR_W-1:0]          rd_addr;
    logic [cnn_pkg::PIX_W-1:0]  rd_data;

    logic [cnn_pkg::PIX_W-1:0]  norm_pixel_in;
    logic                       norm_valid_in;
    logic [cnn_pkg::Q88_W-1:0]  norm_pixel_out;
    logic                       norm_valid_out;

    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [cnn_pkg::Q88_W-1:0]  wr_data;
    logic                       wr_ready;

    modport master (
        output rd_en, rd_addr, norm_pixel_in, norm_valid_in, wr_en, wr_addr, wr_data,
        input  rd_data, norm_pixel_out, norm_valid_out, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, norm_pixel_in, norm_valid_in, wr_en, wr_addr, wr_data,
        output rd_data, norm_pixel_out, norm_valid_out, wr_ready
    );

endinterface : norm_frame_ctrl_if

// File: rtl/norm_out_fifo.sv
// -----------------------------------------------------------------------------
// norm_out_fifo
// Synchronous FIFO buffering normalizer results ahead of the write port.
// Head data is presented combinationally (first-word fall-through).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write side; ignored when full
//   pop             : read side; ignored when empty
//   head            : current head entry
//   full, empty     : status flags
//   count           : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module norm_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, and consumers gate head with empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : norm_out_fifo

// File: rtl/pixel_normalizer.sv
// -----------------------------------------------------------------------------
// pixel_normalizer
// Maps an 8-bit pixel x to x/255 in Q8.8 (floor(x*256/255)), so 0 -> 0x0000
// and 255 -> 0x0100 (1.0). Pure pipeline of LAT stages; valid follows data.
// Lives beside the controller, which only sees its ports through the bus.
// Ports:
//   clk, rst             : clock, synchronous active-high reset (clears valid)
//   pixel_in, valid_in   : input sample
//   pixel_out, valid_out : Q8.8 result, LAT cycles after valid_in
// -----------------------------------------------------------------------------
module pixel_normalizer
    import cnn_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             valid_in,
    output logic [Q88_W-1:0] pixel_out,
    output logic             valid_out
);

    logic [Q88_W-1:0] scaled;
    logic [Q88_W-1:0] data_q [LAT];
    logic [LAT-1:0]   valid_q;

    assign scaled = {pixel_in, 8'h00} / Q88_W'(255);

    always_ff @(posedge clk) begin
        data_q[0] <= scaled;
        for (int i = 1; i < LAT; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_in;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign pixel_out = data_q[LAT-1];
    assign valid_out = valid_q[LAT-1];

endmodule : pixel_normalizer

// File: rtl/norm_frame_ctrl.sv
// -----------------------------------------------------------------------------
// norm_frame_ctrl
// Streams one IMG_W x IMG_H frame from a source pixel buffer through an
// external PixelNormalizer into a destination feature buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle frame request (honoured only in IDLE)
//   busy     : high while the frame is in RUN or DRAIN
//   done     : one-cycle frame-complete pulse
//   err      : sticky; normalizer output arrived while in IDLE or with FIFO full
//   bus      : read / normalizer / write paths (norm_frame_ctrl_if.master)
// Reads are throttled so issued-but-unwritten pixels never exceed FIFO_DEPTH;
// every in-flight normalizer result therefore always has a FIFO slot.
// -----------------------------------------------------------------------------
module norm_frame_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int ADDR_W     = 10,
    parameter int NORM_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    norm_frame_ctrl_if.master bus
);

    localparam int N   = IMG_W * IMG_H;
    localparam int CW  = $clog2(N + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] N_C = CW'(N);

    if ((2 ** ADDR_W) < N) begin : g_bad_addr_w
        $error("norm_frame_ctrl: ADDR_W too small for IMG_W*IMG_H");
    end
    if (FIFO_DEPTH < NORM_LAT + 2) begin : g_bad_depth
        $error("norm_frame_ctrl: FIFO_DEPTH must be >= NORM_LAT+2");
    end

    frame_state_e       state;
    frame_state_e       next_state;
    logic [CW-1:0]      issued;
    logic [CW-1:0]      written;
    logic [CW-1:0]      outstanding;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic               rd_en_c;
    logic               norm_valid_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic [Q88_W-1:0]   fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCW-1:0]     fifo_count;

    assign outstanding = issued - written;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        rd_en_c    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                rd_en_c = (issued < N_C) && (32'(outstanding) < FIFO_DEPTH);
                if (rd_en_c && (issued == N_C - CW'(1))) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (written == N_C) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- counters, addresses, flags ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            issued       <= '0;
            written      <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            norm_valid_q <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                issued    <= '0;
                written   <= '0;
                rd_addr_q <= '0;
                wr_addr_q <= '0;
            end else begin
                if (rd_en_c) begin
                    issued    <= issued + CW'(1);
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
                if (fifo_pop) begin
                    written   <= written + CW'(1);
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                end
            end
            // The source RAM returns data one cycle after rd_en.
            norm_valid_q <= rd_en_c;
            if (bus.norm_valid_out && (fifo_full || state == IDLE)) begin
                err <= 1'b1;
            end
        end
    end

    // ---------------- output FIFO ----------------
    // Results arriving in IDLE belong to an aborted frame and are discarded.
    assign fifo_push = bus.norm_valid_out && !fifo_full && (state != IDLE);
    assign fifo_pop  = bus.wr_en && bus.wr_ready;

    norm_out_fifo #(
        .WIDTH (Q88_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.norm_pixel_out),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- bus outputs ----------------
    assign bus.rd_en         = rd_en_c;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.norm_valid_in = norm_valid_q;
    assign bus.norm_pixel_in = norm_valid_q ? bus.rd_data : '0;
    assign bus.wr_en         = !fifo_empty;
    assign bus.wr_data       = fifo_empty ? '0 : fifo_head;
    assign bus.wr_addr       = wr_addr_q;

    // The FIFO only holds results of reads already issued and not yet
    // written, so its fill level can never exceed the outstanding count.
    fifo_bounded: assert property (@(posedge clk) disable iff (rst)
        32'(fifo_count) <= 32'(outstanding));

endmodule : norm_frame_ctrl

// File: tb/tb_norm_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_norm_frame_ctrl
// Directed bench: controller + pixel_normalizer + 1-cycle source RAM model,
// 4x4 frame, FIFO_DEPTH 4, NORM_LAT 1.
// -----------------------------------------------------------------------------
module tb_norm_frame_ctrl;
    import cnn_pkg::*;

    localparam int IMG_W      = 4;
    localparam int IMG_H      = 4;
    localparam int ADDR_W     = 10;
    localparam int NORM_LAT   = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int N          = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_norm = 1'b1;
    logic start = 1'b0;
    logic wr_ready = 1'b1;
    logic force_nv = 1'b0;
    logic busy, done, err;
    logic nz_valid;

    logic [7:0]  ram      [N];
    logic [15:0] exp_data [N];

    norm_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    norm_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .NORM_LAT(NORM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err),
        .bus(bus)
    );

    pixel_normalizer #(.LAT(NORM_LAT)) u_norm (
        .clk(clk), .rst(rst_norm),
        .pixel_in(bus.norm_pixel_in), .valid_in(bus.norm_valid_in),
        .pixel_out(bus.norm_pixel_out), .valid_out(nz_valid)
    );

    assign bus.norm_valid_out = nz_valid | force_nv;
    assign bus.wr_ready       = wr_ready;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr[3:0]];
    end

    // ---------------- monitor (samples at negedge) ----------------
    int          cyc = 0;
    int          rd_cnt, wr_cnt, done_cnt, first_rd, first_wr, max_out;
    int          stall_cnt, unstable_cnt;
    logic        stall_prev;
    logic [ADDR_W-1:0] prev_addr;
    logic [15:0] prev_data;
    logic [ADDR_W-1:0] log_addr [$];
    logic [15:0] log_data [$];
    int          log_cyc  [$];

    always @(negedge clk) begin
        cyc++;
        if (bus.rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            rd_cnt++;
        end
        if (bus.wr_en && first_wr < 0) first_wr = cyc;
        if (bus.wr_en && bus.wr_ready) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
            log_cyc.push_back(cyc);
            wr_cnt++;
        end
        if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
        if (done) done_cnt++;
        if (stall_prev && (bus.wr_addr != prev_addr || bus.wr_data != prev_data)) unstable_cnt++;
        if (bus.wr_en && !bus.wr_ready) stall_cnt++;
        stall_prev = bus.wr_en && !bus.wr_ready;
        prev_addr  = bus.wr_addr;
        prev_data  = bus.wr_data;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_rd = -1; first_wr = -1;
        max_out = 0; stall_cnt = 0; unstable_cnt = 0; stall_prev = 1'b0;
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b1; rst_norm = 1'b1;
        tick(); tick();
        rst = 1'b0; rst_norm = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {26'd0, busy, done, err, bus.rd_en, bus.norm_valid_in, bus.wr_en}, 32'd0);
        check({tag, "_pix_in"}, bus.norm_pixel_in, 32'd0);
        check({tag, "_addrs"}, {bus.rd_addr, bus.wr_addr}, 32'd0);
        check({tag, "_wr_data"}, bus.wr_data, 32'd0);
    endtask

    // Pixel (i*16) normalizes to floor(4096*i/255) = 16*i for i <= 15.
    task automatic load_nominal();
        for (int i = 0; i < N; i++) begin
            ram[i]      = 8'(16 * i);
            exp_data[i] = 16'(16 * i);
        end
    endtask

    // Start a frame, optionally stall the write port and/or re-pulse start,
    // then wait (bounded) for done.
    task automatic run_frame(input int stall_at, input int stall_len, input int restart_at);
        clear_log();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int c = 1; c < 400 && done_cnt == 0; c++) begin
            start = (c == restart_at);
            if (c == stall_at) wr_ready = 1'b0;
            if (c == stall_at + stall_len) wr_ready = 1'b1;
            tick();
        end
        start = 1'b0; wr_ready = 1'b1;
        check("frame_timeout", done_cnt != 0, 1);
        tick();
        check("busy_after_done", busy, 0);
        repeat (20) tick();
    endtask

    task automatic check_frame(input string tag, input logic exp_err);
        check({tag, "_writes"}, wr_cnt, N);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_err"}, err, exp_err);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hDEAD_BEEF, i);
            check($sformatf("%s_data%0d", tag, i),
                  (i < log_data.size()) ? 32'(log_data[i]) : 32'hDEAD_BEEF, exp_data[i]);
        end
    endtask

    initial begin
        load_nominal();
        clear_log();
        reset_dut();
        check_idle_outputs("reset");

        // Nominal
        run_frame(-1, 0, -1);
        check_frame("nom", 1'b0);
        check("nom_latency", first_wr - first_rd, NORM_LAT + 2);
        check("nom_back_to_back", (log_cyc.size() == N) ? log_cyc[N-1] - log_cyc[0] : -1, N - 1);
        check("nom_max_outstanding", max_out, 3);

        // Backpressure: 10 stalled cycles mid-frame
        run_frame(6, 10, -1);
        check_frame("bp", 1'b0);
        check("bp_max_outstanding", max_out, FIFO_DEPTH);
        check("bp_stall_cycles", stall_cnt, 10);
        check("bp_hold_stable", unstable_cnt, 0);

        // Boundary pixels
        ram[0] = 8'd0; ram[1] = 8'd255; ram[2] = 8'd127; ram[3] = 8'd64;
        exp_data[0] = 16'h0000; exp_data[1] = 16'h0100;
        exp_data[2] = 16'h007F; exp_data[3] = 16'h0040;
        run_frame(-1, 0, -1);
        check_frame("bnd", 1'b0);
        load_nominal();

        // Start while busy (second start in frame cycle 5)
        run_frame(-1, 0, 4);
        check_frame("sb", 1'b0);

        // Reset mid-frame at the 7th write
        clear_log();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 0; c < 200 && wr_cnt < 7; c++) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_reached", wr_cnt, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        tick();
        check("rst_inflight_err", err, 1);
        repeat (10) tick();
        check("rst_no_more_writes", wr_cnt, 7);
        check("rst_no_done", done_cnt, 0);
        run_frame(-1, 0, -1);
        check_frame("rst_restart", 1'b1);

        // Overflow: normalizer output while IDLE
        reset_dut();
        check("ovf_err_cleared", err, 0);
        tick(); force_nv = 1'b1;
        tick(); force_nv = 1'b0;
        check("ovf_err_set", err, 1);
        repeat (5) tick();
        check("ovf_err_sticky", err, 1);
        check("ovf_no_write", bus.wr_en, 0);
        reset_dut();
        check("ovf_err_rst", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_norm_frame_ctrl

// File: doc/norm_frame_ctrl.md
NORM_FRAME_CTRL -- requirements
Module: norm_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame.
- ADDR_W, 10, buffer address width; the design requires 2**ADDR_W >= IMG_W*IMG_H.
- NORM_LAT, 1, PixelNormalizer valid_in-to-valid_out latency in cycles.
- FIFO_DEPTH, 4, output FIFO entries; the design requires FIFO_DEPTH >= NORM_LAT+2.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- start, in, 1, one-cycle frame request.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle frame-complete pulse.
- err, out, 1, sticky protocol/overflow flag.
- rd_en, out, 1, source pixel-buffer read strobe.
- rd_addr, out, ADDR_W, source pixel address.
- rd_data, in, 8, pixel; valid exactly 1 cycle after rd_en.
- norm_pixel_in, out, 8, to normalizer pixel_in.
- norm_valid_in, out, 1, to normalizer valid_in.
- norm_pixel_out, in, 16, from normalizer pixel_out (Q8.8).
- norm_valid_out, in, 1, from normalizer valid_out.
- wr_en, out, 1, destination feature-buffer write strobe.
- wr_addr, out, ADDR_W, destination address.
- wr_data, out, 16, normalized pixel.
- wr_ready, in, 1, destination accepts; a write completes on wr_en && wr_ready.

Function
REQ-003 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE -> RUN on start; this clears issue count, write count, rd_addr and wr_addr to 0. start is ignored outside IDLE.
REQ-005 In RUN, rd_en SHALL assert in a cycle iff issued < N (N = IMG_W*IMG_H) and outstanding < FIFO_DEPTH, where outstanding = issued - written.
REQ-006 rd_addr increments by 1 after each rd_en cycle, and the first read is at address 0.
REQ-007 RUN -> DRAIN in the cycle after the Nth rd_en.
REQ-008 norm_valid_in is rd_en delayed 1 cycle; norm_pixel_in = rd_data in that cycle; norm_pixel_in is 0 when norm_valid_in is low.
REQ-009 Each cycle with norm_valid_out high pushes norm_pixel_out into the output FIFO (norm_out_fifo); order is preserved.
REQ-010 wr_en = FIFO not empty; wr_data = FIFO head.
REQ-011 The FIFO pops and wr_addr increments only on wr_en && wr_ready.
REQ-012 wr_data and wr_addr SHALL hold stable while wr_en && !wr_ready.
REQ-013 A simultaneous push and pop leaves the FIFO count unchanged, and a push into an empty FIFO is visible at wr_en the next cycle.
REQ-014 DRAIN -> DONE when written == N.
REQ-015 DONE asserts done for exactly 1 cycle, then goes to IDLE.
REQ-016 busy is high in RUN and DRAIN only.
REQ-017 Throughput: with wr_ready held high, the controller sustains 1 pixel/cycle. Latency from the first rd_en to the first wr_en is NORM_LAT+2 cycles.
REQ-018 err sets and stays set on either condition; err clears only on rst:
- norm_valid_out with the FIFO full (the incoming data is dropped);
- norm_valid_out while in IDLE.
REQ-019 Issue and write counters are $clog2(N+1) bits wide; all counters saturate-free because the design never exceeds N.

Reset
REQ-020 On rst: FSM = IDLE; all counters, addresses and the FIFO are cleared.
REQ-021 On rst: busy, done, err, rd_en, norm_valid_in and wr_en are 0; norm_pixel_in, rd_addr, wr_addr and wr_data are 0.
REQ-022 rst mid-frame aborts the frame within 1 cycle, with no done pulse, and any in-flight normalizer outputs arriving in IDLE afterwards set err.

Structure
REQ-023 The state enum (IDLE, RUN, DRAIN, DONE) and the Q8.8 pixel width constant SHALL reside in the shared package cnn_pkg.
REQ-024 The output FIFO SHALL be a separate sub-module, norm_out_fifo, parameterised by width 16 and depth FIFO_DEPTH, with full, empty and count outputs.
REQ-025 The PixelNormalizer is not instantiated inside; the controller connects to it at top level.

Verification
REQ-026 The bench SHALL pair the controller with the real PixelNormalizer and a 1-cycle-latency source RAM model, and SHALL cover these directed scenarios:
- Nominal: IMG_W=IMG_H=4, RAM[i]=16*i, wr_ready=1, start pulse -> 16 writes at addr 0..15 on consecutive cycles; wr_data[i] = normalizer(16*i); done pulses once; busy is low after done.
- Backpressure: same frame with wr_ready low for 10 cycles mid-frame -> rd_en halts once outstanding = 4; no data lost; written data and order match the nominal scenario; err stays 0.
- Boundary pixels: RAM = {0, 255, 127, 64} -> wr_data equals normalizer outputs for 0, 255, 127 and 64 in order.
- Start while busy: a second start at cycle 5 of a frame -> ignored; exactly 16 writes; one done.
- Reset mid-frame: rst at the 7th write -> all outputs are 0 the next cycle; a subsequent start completes a full 16-pixel frame from addr 0.
- Overflow check: force norm_valid_out high in IDLE -> err=1 and it persists until rst.
